score_uart_reporter: RTL
========================

# score_uart_reporter

Formats game score events into ASCII messages and streams them byte by byte into the `uart_tx` transmitter through its `tx_start`/`tx_data`/`tx_busy` handshake. It sits between `score_counter`/`game_fsm` and `uart_tx` in `top_whackamole`. It reports every score change during a game as `S=NN\r\n` and the final score as `END NN\r\n` when the game ends.

## Interface
- `REPORT_UPDATES`, default 1: 1 sends a message on every in-game score change; 0 sends only the end-of-game message.
- `clock` input 1: 100 MHz system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high; the only clock is `clock`.
- `score` input 6: current score from `score_counter`, unsigned, range 0..63.
- `game_active` input 1: game status from `game_fsm`.
- `tx_busy` input 1: from `uart_tx`; high while a byte is being shifted out.
- `tx_start` output 1: single-cycle request to `uart_tx`.
- `tx_data` output 8: byte to send; valid in the `tx_start` cycle and held until the next load.
- `sending` output 1: high from message load until the last byte's `tx_busy` falls.

## Operation
- **Edge detection.** Registers `score_prev` and `active_prev` update every cycle.
  - Update trigger: `game_active && score != score_prev && REPORT_UPDATES`.
  - End trigger: `active_prev && !game_active`.
- **Request slots.**
  - Update slot: one deep; a new update trigger overwrites it with the latest `score`. Changes are coalesced, not queued.
  - End slot: one deep; holds the `score` value at the falling edge.
  - Setting the end slot clears any pending update.
  - If both triggers fire in the same cycle, only the end request is kept.
- **Snapshot.** On leaving IDLE the chosen request's score is copied into `snap`. Later `score` changes do not alter an in-flight message.
- **Digits.** `tens = snap / 10` (0..6) and `ones = snap % 10`, either combinational or by repeated subtraction of 10 in LOAD. ASCII value is `8'h30 + digit`. There is no leading-zero suppression; 7 prints as `07`.
- **Messages.**
  - Update, 6 bytes: 0x53 0x3D tens ones 0x0D 0x0A.
  - End, 8 bytes: 0x45 0x4E 0x44 0x20 tens ones 0x0D 0x0A.
- **FSM.**
  - IDLE: if end slot set, take end; else if update slot set, take update; else stay. Taking a request clears its slot, snapshots the score, zeroes the byte index and goes to LOAD.
  - LOAD: drive `tx_data` = byte[index]. If `tx_busy` is low, go to START; otherwise stay.
  - START: `tx_start`=1 for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for `tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for `tx_busy`=0. Then increment the index: go to LOAD if bytes remain, else IDLE.
- **Triggers while sending.** Triggers are captured into the slots in every state and serviced from IDLE after the current message ends.
- **`sending`.** Equals (state != IDLE).

## Timing
- **Reset values.** `tx_start`=0, `tx_data`=8'h00, `sending`=0, state IDLE, both slots clear. `score_prev` and `active_prev` load their current inputs, so no trigger fires in the first cycle after reset.
- **Reset priority.** Reset mid-message aborts immediately: no further `tx_start`, and the partial message is not resumed.
- **Trigger latency.** Trigger seen at edge N with IDLE and `tx_busy` low: slot set at N, LOAD at N+1, `tx_start` high in cycle N+2 → N+3.
- **Byte spacing.** Minimum 2 cycles from `tx_busy` falling to the next `tx_start`, via LOAD then START.
- **Start contract.**
  - `tx_start` never asserts while `tx_busy`=1.
  - `tx_start` is never high two consecutive cycles.
  - `uart_tx` must raise `tx_busy` within 1 cycle of `tx_start`.
- **Back-to-back messages.** After the last byte, IDLE takes a pending slot the next cycle.

## Test plan
- **Reset.** Hold `reset` 3 cycles with `score`=12 and `game_active`=1 → `tx_start`=0, `tx_data`=0x00, `sending`=0; no message after release with inputs static.
- **Single update.** `game_active`=1, `score` 0→5, UART model busy 20 cycles per byte → bytes 0x53 0x3D 0x30 0x35 0x0D 0x0A in order. Each `tx_start` is 1 cycle wide and occurs only with `tx_busy`=0. The first `tx_start` arrives 2 cycles after the change.
- **Coalescing.** During the first message, `score` steps 5→6→7→8 → exactly one more message, `S=08\r\n`; total 12 bytes.
- **End of game.** `score`=63, `game_active` 1→0 with an update pending → message `END 63\r\n` (0x45 0x4E 0x44 0x20 0x36 0x33 0x0D 0x0A); no `S=` message is sent for the pending update.
- **REPORT_UPDATES=0.** `score` changes 3 times in game, then game ends at 42 → only `END 42\r\n` is emitted.
- **Reset mid-message.** Assert `reset` in WAIT_DONE of byte 3 → `sending`=0 the next cycle; no further `tx_start` until a new trigger.

Source files
------------

// File: rtl/score_uart_reporter_if.sv
// score_uart_reporter_if
//   Groups the reporter's game-side inputs, the uart_tx handshake and the
//   status output into one bundle.
//   master : the reporter (drives tx_start, tx_data, sending)
//   slave  : the environment (drives score, game_active, tx_busy)
//   Signals:
//     score[5:0]   current score, 0..63
//     game_active  game running flag
//     tx_busy      uart_tx is shifting a byte
//     tx_start     one-cycle byte request to uart_tx
//     tx_data[7:0] byte to send, held until the next load
//     sending      a message is in progress
interface score_uart_reporter_if;
    logic [5:0] score;
    logic       game_active;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       sending;

    modport master (input  score, game_active, tx_busy,
                    output tx_start, tx_data, sending);
    modport slave  (output score, game_active, tx_busy,
                    input  tx_start, tx_data, sending);
endinterface

// File: rtl/score_uart_reporter.sv
// score_uart_reporter
//   Turns score changes into "S=NN\r\n" and the end of a game into
//   "END NN\r\n", streamed one byte at a time into uart_tx.
//   Ports:
//     clock  system clock, rising edge
//     reset  synchronous, active high
//     bus    score_uart_reporter_if.master (score, game_active, tx_busy in;
//            tx_start, tx_data, sending out)
//   Parameter:
//     REPORT_UPDATES  1: report every in-game change, 0: only the final score
module score_uart_reporter #(
    parameter bit REPORT_UPDATES = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    score_uart_reporter_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE
    } state_t;

    state_t     r_state, w_next;
    logic [5:0] r_score_prev;
    logic       r_active_prev;
    logic       r_upd_pend, r_end_pend;
    logic [5:0] r_upd_score, r_end_score, r_snap;
    logic       r_is_end;
    logic [2:0] r_idx;
    logic [7:0] r_tx_data;

    logic       w_upd_trig, w_end_trig;
    logic       w_take_end, w_take_upd;
    logic       w_last;
    logic [5:0] w_tens, w_ones;
    logic [7:0] w_tens_a, w_ones_a, w_byte;

    assign w_upd_trig = REPORT_UPDATES && bus.game_active && (bus.score != r_score_prev);
    assign w_end_trig = r_active_prev && !bus.game_active;

    assign w_tens   = r_snap / 6'd10;
    assign w_ones   = r_snap % 6'd10;
    assign w_tens_a = 8'h30 + {2'b00, w_tens};
    assign w_ones_a = 8'h30 + {2'b00, w_ones};
    assign w_last   = (r_idx == (r_is_end ? 3'd7 : 3'd5));

    // Byte at the current index of the message being sent.
    always_comb begin
        w_byte = 8'h00;
        if (r_is_end) begin
            case (r_idx)
                3'd0:    w_byte = 8'h45;
                3'd1:    w_byte = 8'h4E;
                3'd2:    w_byte = 8'h44;
                3'd3:    w_byte = 8'h20;
                3'd4:    w_byte = w_tens_a;
                3'd5:    w_byte = w_ones_a;
                3'd6:    w_byte = 8'h0D;
                default: w_byte = 8'h0A;
            endcase
        end else begin
            case (r_idx)
                3'd0:    w_byte = 8'h53;
                3'd1:    w_byte = 8'h3D;
                3'd2:    w_byte = w_tens_a;
                3'd3:    w_byte = w_ones_a;
                3'd4:    w_byte = 8'h0D;
                3'd5:    w_byte = 8'h0A;
                default: w_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        w_take_end = 1'b0;
        w_take_upd = 1'b0;
        case (r_state)
            S_IDLE: begin
                // End of game always wins over a pending update.
                if (r_end_pend) begin
                    w_take_end = 1'b1;
                    w_next     = S_LOAD;
                end else if (r_upd_pend) begin
                    w_take_upd = 1'b1;
                    w_next     = S_LOAD;
                end
            end
            S_LOAD:      if (!bus.tx_busy) w_next = S_START;
            S_START:     w_next = S_WAIT_ACK;
            S_WAIT_ACK:  if (bus.tx_busy) w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!bus.tx_busy) w_next = w_last ? S_IDLE : S_LOAD;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Prev registers track inputs so nothing fires right after reset.
            r_score_prev  <= bus.score;
            r_active_prev <= bus.game_active;
            r_upd_pend    <= 1'b0;
            r_end_pend    <= 1'b0;
            r_upd_score   <= 6'd0;
            r_end_score   <= 6'd0;
            r_snap        <= 6'd0;
            r_is_end      <= 1'b0;
            r_idx         <= 3'd0;
            r_tx_data     <= 8'h00;
        end else begin
            r_score_prev  <= bus.score;
            r_active_prev <= bus.game_active;

            if (w_take_end) begin
                r_end_pend <= 1'b0;
                r_snap     <= r_end_score;
                r_is_end   <= 1'b1;
                r_idx      <= 3'd0;
            end else if (w_take_upd) begin
                r_upd_pend <= 1'b0;
                r_snap     <= r_upd_score;
                r_is_end   <= 1'b0;
                r_idx      <= 3'd0;
            end

            if (r_state == S_LOAD) r_tx_data <= w_byte;
            if (r_state == S_WAIT_DONE && !bus.tx_busy) r_idx <= r_idx + 3'd1;

            // Placed after the take logic so a trigger in the same cycle
            // re-arms the slot instead of being lost.
            if (w_end_trig) begin
                r_end_pend  <= 1'b1;
                r_end_score <= bus.score;
                r_upd_pend  <= 1'b0;
            end else if (w_upd_trig) begin
                r_upd_pend  <= 1'b1;
                r_upd_score <= bus.score;
            end
        end
    end

    assign bus.tx_start = (r_state == S_START);
    assign bus.tx_data  = r_tx_data;
    assign bus.sending  = (r_state != S_IDLE);

endmodule
